// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU control decode plus multi-cycle MUL/DIVU sequencer (DIVU enabled by ALU_CTRL_SEQ_DIV_EN)
module alu_ctrl_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       aluOp,
  input  logic [5:0]       funct,
  input  logic             inValid,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [3:0]       aluCntrl,
  output logic             stall,
  output logic             mdDone,
  output logic [WIDTH-1:0] mdResult,
  output logic [WIDTH-1:0] mdRem
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opa, opb, acc, acc_mul;
  logic [3:0] r_cntrl;
  logic is_mul, md_op, busy, start;
  assign is_mul = aluOp == 2'b10 && funct == 6'b011100;
  assign start = inValid && md_op && state == IDLE;
  assign stall = rst_n && (start || busy);
  assign mdDone = state == DONE;
  assign acc_mul = opb[0] ? acc + opa : acc;
  assign aluCntrl = aluOp == 2'b00 ? 4'b0010 : aluOp == 2'b01 ? 4'b0100 : aluOp == 2'b11 ? 4'b0001 : r_cntrl;
`ifdef ALU_CTRL_SEQ_DIV_EN
  localparam logic [1:0] DIV = 2'd2;
  logic is_div, div_ge;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH-1:0] acc_div, q_div, rem_q;
  assign is_div = aluOp == 2'b10 && funct == 6'b011011;
  assign md_op = is_mul || is_div;
  assign busy = state == MUL || state == DIV;
  assign rem_sh = {acc, opa[WIDTH-1]};
  assign div_ge = rem_sh >= {1'b0, opb};
  assign acc_div = div_ge ? WIDTH'(rem_sh - {1'b0, opb}) : rem_sh[WIDTH-1:0];
  assign q_div = {opa[WIDTH-2:0], div_ge};
  assign mdRem = rem_q;
`else
  assign md_op = is_mul;
  assign busy = state == MUL;
  assign mdRem = '0;
`endif
  // R-type function decode; unknown functs fall back to ADD
  always_comb begin
    r_cntrl = funct == 6'b100010 ? 4'b0100 :
              funct == 6'b100100 ? 4'b0000 :
              funct == 6'b100101 ? 4'b0001 :
              funct == 6'b101010 ? 4'b0110 :
              funct == 6'b011100 ? 4'b0101 : 4'b0010;
`ifdef ALU_CTRL_SEQ_DIV_EN
    if (funct == 6'b011011) r_cntrl = 4'b0111;
`endif
  end
  // sequencer: latch operands, iterate one bit per cycle, publish on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      opa <= '0;
      opb <= '0;
      acc <= '0;
      mdResult <= '0;
`ifdef ALU_CTRL_SEQ_DIV_EN
      rem_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          opa <= srcA;
          opb <= srcB;
          acc <= '0;
          cnt <= CNT_W'(WIDTH);
`ifdef ALU_CTRL_SEQ_DIV_EN
          state <= is_mul ? MUL : DIV;
`else
          state <= MUL;
`endif
        end
        MUL: begin
          acc <= acc_mul;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            mdResult <= acc_mul;
`ifdef ALU_CTRL_SEQ_DIV_EN
            rem_q <= '0;
`endif
          end
        end
`ifdef ALU_CTRL_SEQ_DIV_EN
        DIV: begin
          acc <= acc_div;
          opa <= q_div;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            mdResult <= q_div;
            rem_q <= acc_div;
          end
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (8..64).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), iteration counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port aluOp  input  2  main-decoder ALU class.
REQ-006 SHALL have port funct  input  6  R-type function field.
REQ-007 SHALL have port inValid  input  1  instruction present this cycle.
REQ-008 SHALL have ports srcA, srcB  input  WIDTH  multi-cycle operands.
REQ-009 SHALL have port aluCntrl  output  4  combinational ALU select.
REQ-010 SHALL have port stall  output  1  hold PC/pipeline while high.
REQ-011 SHALL have port mdDone  output  1  one-cycle multi-cycle completion pulse.
REQ-012 SHALL have ports mdResult, mdRem  output  WIDTH  product/quotient and remainder.

Function
REQ-013 aluCntrl SHALL decode: aluOp 00 -> 0010 ADD; 01 -> 0100 SUB; 11 -> 0001 OR; 10 by funct: 100000 ADD 0010, 100010 SUB 0100, 100100 AND 0000, 100101 OR 0001, 101010 SLT 0110, 011100 MUL 0101, 011011 DIVU 0111; any other -> 0010.
REQ-014 Multi-cycle ops SHALL be aluOp=10 with funct 011100 (MUL) or 011011 (DIVU).
REQ-015 FSM states SHALL be IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-016 IDLE: inValid and multi-cycle op SHALL latch srcA/srcB, load counter with WIDTH, go MUL or DIV; otherwise stay IDLE.
REQ-017 stall SHALL be combinational: 1 in IDLE when inValid and multi-cycle op, 1 in MUL/DIV, 0 in IDLE otherwise and in DONE.
REQ-018 MUL SHALL perform one shift-add step per cycle, accumulating low WIDTH bits of srcA*srcB (mod 2^WIDTH), decrementing counter.
REQ-019 DIV SHALL perform one restoring-division step per cycle, unsigned, decrementing counter.
REQ-020 MUL/DIV SHALL go to DONE on the cycle the counter decrements to 0; total stall high = WIDTH+1 cycles, mdDone in the next cycle.
REQ-021 DONE SHALL assert mdDone for exactly one cycle, hold mdResult/mdRem, ignore inputs, return to IDLE.
REQ-022 mdResult/mdRem SHALL only change on DONE entry; MUL writes mdRem=0.
REQ-023 DIVU with srcB=0 SHALL give mdResult all-ones and mdRem=srcA, with identical latency.
REQ-024 Single-cycle ops SHALL never assert stall or mdDone nor alter mdResult/mdRem.
REQ-025 Inputs changing during MUL/DIV SHALL have no effect on the running operation.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counter 0, operand/accumulator registers 0, mdResult=0, mdRem=0, mdDone=0.
REQ-027 Reset mid-operation SHALL abort it with no mdDone; stall SHALL be 0 while rst_n low.
REQ-028 First operation after reset release SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-029 Macro ALU_CTRL_SEQ_DIV_EN defined SHALL include DIVU decode, DIV state and divider datapath.
REQ-030 Without ALU_CTRL_SEQ_DIV_EN, funct 011011 SHALL decode as default ADD 0010, never stall; DIV state and divider logic absent, mdRem constant 0.

Verification
REQ-031 WIDTH=32, aluOp=10 funct=101010 inValid=1 -> aluCntrl=0110, stall=0, mdDone never 1.
REQ-032 MUL srcA=7 srcB=6 -> stall high 33 cycles, then mdDone=1 one cycle, mdResult=42, mdRem=0.
REQ-033 MUL srcA=0xFFFFFFFF srcB=2 -> mdResult=0xFFFFFFFE (wrap), same latency.
REQ-034 DIV_EN: DIVU srcA=100 srcB=7 -> mdResult=14, mdRem=2; srcB=0 -> mdResult=0xFFFFFFFF, mdRem=100.
REQ-035 rst_n low at stall cycle 10 of MUL -> stall=0 immediately, no mdDone, mdResult=0; next MUL 3*3 -> 9.
REQ-036 Without DIV_EN: aluOp=10 funct=011011 -> aluCntrl=0010, stall=0.
